// File: rtl/data_pack.sv
// data_pack: repacks a stream of 7-bit values into LSB-first 32-bit words with sop/eop,
// buffered in a small output FIFO with a ready/valid handshake.
// Optional feature macro DATA_PACK_VALID_BITS_EN adds bits_out, the count of meaningful
// bits in the head word.
module data_pack #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [6:0]  data_in,
    input  logic        sop_in,
    input  logic        eop_in,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic        sop_out,
    output logic        eop_out,
    output logic        overflow,
`ifdef DATA_PACK_VALID_BITS_EN
    output logic [5:0]  bits_out,
`endif
    output logic        proto_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, PACK} state_t;

    state_t      state;
    logic [37:0] acc;
    logic [5:0]  cnt;
    logic        first;

    logic        tail_valid;
    logic [31:0] tail_data;
    logic        tail_sop;
`ifdef DATA_PACK_VALID_BITS_EN
    logic [5:0]  tail_bits;
`endif

    logic        restart;
    logic        active;
    logic        close_pkt;
    logic [37:0] base_acc;
    logic [37:0] ins_acc;
    logic [5:0]  base_cnt;
    logic [5:0]  total;
    logic        base_first;
    logic        word_push;

    // Beat decode: a restart (sop) starts from an empty accumulator, then the value is inserted.
    always_comb begin
        restart    = valid_in & sop_in & ((state == IDLE) | ~eop_in);
        active     = valid_in & ((state == PACK) | sop_in);
        close_pkt  = active & eop_in;
        base_acc   = restart ? '0 : acc;
        base_cnt   = restart ? '0 : cnt;
        base_first = restart | first;
        ins_acc    = base_acc | ({31'd0, data_in} << base_cnt);
        total      = base_cnt + 6'd7;
        // A close with exactly 32 bits leaves the whole word for the tail.
        word_push  = active & (close_pkt ? (total > 6'd32) : (total >= 6'd32));
    end

    // Packing FSM, accumulator and tail register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            first      <= 1'b1;
            tail_valid <= 1'b0;
            tail_data  <= '0;
            tail_sop   <= 1'b0;
`ifdef DATA_PACK_VALID_BITS_EN
            tail_bits  <= '0;
`endif
            proto_err  <= 1'b0;
        end else begin
            tail_valid <= 1'b0;
            if (valid_in & sop_in & ~eop_in & (state == PACK)) begin
                proto_err <= 1'b1;
            end
            if (close_pkt) begin
                tail_valid <= 1'b1;
                if (total > 6'd32) begin
                    tail_data <= {26'd0, ins_acc[37:32]};
                    tail_sop  <= 1'b0;
`ifdef DATA_PACK_VALID_BITS_EN
                    tail_bits <= total - 6'd32;
`endif
                end else begin
                    tail_data <= ins_acc[31:0];
                    tail_sop  <= base_first;
`ifdef DATA_PACK_VALID_BITS_EN
                    tail_bits <= total;
`endif
                end
                acc   <= '0;
                cnt   <= '0;
                first <= 1'b1;
                state <= ((state == PACK) & sop_in) ? PACK : IDLE;
            end else if (active) begin
                state <= PACK;
                if (word_push) begin
                    acc   <= ins_acc >> 32;
                    cnt   <= total - 6'd32;
                    first <= 1'b0;
                end else begin
                    acc   <= ins_acc;
                    cnt   <= total;
                    first <= base_first;
                end
            end
        end
    end

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] mem_data [FIFO_DEPTH];
    logic        mem_sop  [FIFO_DEPTH];
    logic        mem_eop  [FIFO_DEPTH];
`ifdef DATA_PACK_VALID_BITS_EN
    logic [5:0]  mem_bits [FIFO_DEPTH];
    logic [5:0]  push_bits;
`endif
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        do_push;
    logic [31:0] push_data;
    logic        push_sop;
    logic        push_eop;

    // FIFO control; the tail and a full word never compete for the same cycle.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = ~empty & ready_in;
        push_req  = tail_valid | word_push;
        do_push   = push_req & (~full | pop);
        push_data = tail_valid ? tail_data : ins_acc[31:0];
        push_sop  = tail_valid ? tail_sop : base_first;
        push_eop  = tail_valid;
`ifdef DATA_PACK_VALID_BITS_EN
        push_bits = tail_valid ? tail_bits : 6'd32;
`endif
    end

    // FIFO pointers and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req & full & ~pop) overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr[AW-1:0]] <= push_data;
            mem_sop[wr_ptr[AW-1:0]]  <= push_sop;
            mem_eop[wr_ptr[AW-1:0]]  <= push_eop;
`ifdef DATA_PACK_VALID_BITS_EN
            mem_bits[wr_ptr[AW-1:0]] <= push_bits;
`endif
        end
    end

    // Head presentation; forced to zero while empty.
    always_comb begin
        valid_out = ~empty;
        data_out  = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
        sop_out   = empty ? 1'b0 : mem_sop[rd_ptr[AW-1:0]];
        eop_out   = empty ? 1'b0 : mem_eop[rd_ptr[AW-1:0]];
`ifdef DATA_PACK_VALID_BITS_EN
        bits_out  = empty ? '0 : mem_bits[rd_ptr[AW-1:0]];
`endif
    end

endmodule
